// File: rtl/bus_slave_sram_pkg.sv
// Shared definitions for the bus_slave_sram data-memory responder.
// Covers the rw encoding, FSM state codes, word ranges and wait-counter sizing.
package bus_slave_sram_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        BSS_IDLE = 2'd0,
        BSS_WAIT = 2'd1,
        BSS_RESP = 2'd2
    } bss_state_e;

    // Word index starts above the byte offset; one bus word is one SRAM word.
    localparam int WORD_ADDR_LSB = 2;
    localparam int WORD_DATA_W   = 32;

    localparam int WAIT_CNT_W = 4;

    function automatic logic [WAIT_CNT_W-1:0] wait_init(input int wait_cycles);
        return (wait_cycles > 0) ? WAIT_CNT_W'(wait_cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/bus_slave_sram_if.sv
// Request/strobe/ready bus between a master and one bus_slave_sram responder.
// The err signal exists only when BUS_SLAVE_SRAM_ERR_EN is defined.
interface bus_slave_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cs;
    logic              as;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rdy;
`ifdef BUS_SLAVE_SRAM_ERR_EN
    logic              err;
`endif

    modport master (
        output cs, as, rw, addr, wr_data,
`ifdef BUS_SLAVE_SRAM_ERR_EN
        input  err,
`endif
        input  rd_data, rdy
    );

    modport slave (
        input  cs, as, rw, addr, wr_data,
`ifdef BUS_SLAVE_SRAM_ERR_EN
        output err,
`endif
        output rd_data, rdy
    );

endinterface

// File: rtl/bus_slave_sram_array.sv
// Single-port synchronous SRAM with a registered read port.
// Kept as a separate module so a vendor macro can be dropped in.
module bus_sram_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // rdata holds its last read value across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_slave_sram.sv
// Bus responder fronting a word SRAM with WAIT_CYCLES wait states and a one-cycle rdy.
// Define BUS_SLAVE_SRAM_ERR_EN to add bus err reporting for misaligned/out-of-range accesses.
module bus_slave_sram
    import bus_slave_sram_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = WORD_DATA_W,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rest,
    bus_slave_sram_if.slave bus_s
);

    localparam bit                    ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT  = wait_init(WAIT_CYCLES);

    typedef struct packed {
        logic                  rw;
        logic                  err;
        logic [DEPTH_LOG2-1:0] idx;
        logic [DATA_W-1:0]     wr_data;
    } req_t;

    bss_state_e            state;
    logic [WAIT_CNT_W-1:0] cnt;
    req_t                  req_q;
    req_t                  req_in;
    req_t                  req_cur;
    logic                  rdy_q;
    logic                  accept;
    logic                  fire;
    logic                  sram_en;
    logic                  sram_we;
    logic [DATA_W-1:0]     sram_rdata;
    logic                  unused_addr_bits;

    assign accept = (state == BSS_IDLE) && bus_s.cs && bus_s.as;

    always_comb begin
        req_in         = '0;
        req_in.rw      = bus_s.rw;
        req_in.idx     = bus_s.addr[DEPTH_LOG2+1:WORD_ADDR_LSB];
        req_in.wr_data = bus_s.wr_data;
`ifdef BUS_SLAVE_SRAM_ERR_EN
        req_in.err     = (bus_s.addr[1:0] != 2'b00) ||
                         ((bus_s.addr >> (DEPTH_LOG2 + 2)) != '0);
`endif
    end

    assign unused_addr_bits = ^{bus_s.addr[1:0], bus_s.addr >> (DEPTH_LOG2 + 2)};

    // With no wait states the array is driven straight from the bus at the
    // accepting edge, since the capture registers only load at that same edge.
    assign req_cur = ZERO_WAIT ? req_in : req_q;
    assign fire    = !rest && (ZERO_WAIT ? accept : (state == BSS_WAIT && cnt == '0));
    assign sram_en = fire && !req_cur.err;
    assign sram_we = (req_cur.rw == WRITE);

    bus_sram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (req_cur.idx),
        .wdata (req_cur.wr_data),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rest) begin
            state <= BSS_IDLE;
            cnt   <= '0;
            req_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            case (state)
                BSS_IDLE: begin
                    rdy_q <= 1'b0;
                    if (accept) begin
                        req_q <= req_in;
                        if (ZERO_WAIT) begin
                            state <= BSS_RESP;
                            rdy_q <= 1'b1;
                        end else begin
                            state <= BSS_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BSS_WAIT: begin
                    if (cnt == '0) begin
                        state <= BSS_RESP;
                        rdy_q <= 1'b1;
                    end else begin
                        cnt <= cnt - WAIT_CNT_W'(1);
                    end
                end
                BSS_RESP: begin
                    state <= BSS_IDLE;
                    rdy_q <= 1'b0;
                end
                default: begin
                    state <= BSS_IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    // Gating two registers only: zero outside RESP so the bus can OR slaves together.
    assign bus_s.rdy     = rdy_q;
    assign bus_s.rd_data = (rdy_q && req_q.rw == READ && !req_q.err) ? sram_rdata : '0;
`ifdef BUS_SLAVE_SRAM_ERR_EN
    assign bus_s.err     = rdy_q && req_q.err;
`endif

endmodule
